// File: rtl/usb_seq_pkg.sv
// Shared state type and sizing helpers for the USB STAT sequence matcher.
package usb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_NEXT,
    DONE
  } seq_state_e;

  function automatic int stgWidth(input int stages);
    return $clog2(stages + 1);
  endfunction

  // Zero requested stages behaves as one; oversize requests clamp to the built maximum.
  function automatic int clampStages(input int num, input int maxStages);
    if (num == 0) return 1;
    if (num > maxStages) return maxStages;
    return num;
  endfunction

endpackage

// File: rtl/usb_seq_stage_cmp.sv
// One masked comparator per sequence stage against the live capture status.
module usb_seq_stage_cmp
  import usb_seq_pkg::*;
#(
  parameter int pSTAT_WIDTH = 5,
  parameter int pSTAGES     = 4
) (
  input  logic [pSTAGES*pSTAT_WIDTH-1:0] pattern_i,
  input  logic [pSTAGES*pSTAT_WIDTH-1:0] mask_i,
  input  logic [pSTAT_WIDTH-1:0]         stat_i,
  output logic [pSTAGES-1:0]             match_o
);

  for (genvar k = 0; k < pSTAGES; k++) begin : g_cmp
    logic [pSTAT_WIDTH-1:0] msk;
    assign msk        = mask_i[k*pSTAT_WIDTH +: pSTAT_WIDTH];
    assign match_o[k] = ((stat_i & msk) == (pattern_i[k*pSTAT_WIDTH +: pSTAT_WIDTH] & msk));
  end

endmodule

// File: rtl/usb_stat_seq_matcher.sv
// Recognises an ordered sequence of masked status patterns with per-stage hold
// times and reports the completing sample and the cycles elapsed since arming.
module usb_stat_seq_matcher
  import usb_seq_pkg::*;
#(
  parameter int pSTAT_WIDTH = 5,
  parameter int pSTAGES     = 4,
  parameter int pHOLD_WIDTH = 8,
  parameter int pTS_WIDTH   = 16,
  localparam int pSTG_W     = stgWidth(pSTAGES)
) (
  input  logic                           fe_clk,
  input  logic                           reset_i,
  input  logic                           I_arm,
  input  logic                           I_update,
  input  logic [pSTG_W-1:0]              I_num_stages,
  input  logic [pSTAGES*pSTAT_WIDTH-1:0] I_pattern,
  input  logic [pSTAGES*pSTAT_WIDTH-1:0] I_mask,
  input  logic [pSTAGES*pHOLD_WIDTH-1:0] I_hold,
  input  logic [pSTAT_WIDTH-1:0]         I_fe_capture_stat,
  output logic                           O_match_pulse,
  output logic                           O_matched,
  output logic                           O_busy,
  output logic [pSTG_W-1:0]              O_stage,
  output logic [pSTAT_WIDTH-1:0]         O_match_stat,
  output logic [pTS_WIDTH-1:0]           O_match_time
);

  localparam int pIDX = 2 ** pSTG_W;

  seq_state_e                     state_q, state_d;
  logic [pSTG_W-1:0]              stage_q, stage_d, numStg_q, numEff;
  logic [pSTG_W-1:0]              lastStg, nextStg, candStg;
  logic [pHOLD_WIDTH-1:0]         cnt_q, cnt_d, candCnt;
  logic [pTS_WIDTH-1:0]           timer_q, timer_d, timerInc;
  logic [pTS_WIDTH-1:0]           mTime_q, mTime_d;
  logic [pSTAT_WIDTH-1:0]         mStat_q, mStat_d;
  logic                           matched_q, matched_d, pulse_q, pulse_d, armPrev_q;
  logic [pSTAGES*pSTAT_WIDTH-1:0] pattern_q, mask_q;
  logic [pSTAGES*pHOLD_WIDTH-1:0] hold_q;
  logic [pSTAGES-1:0]             matchVec;
  logic [pIDX-1:0]                matchPad;
  logic [pHOLD_WIDTH-1:0]         holdArr [pIDX];
  logic                           startEv, armFall, evalEn;

  usb_seq_stage_cmp #(
    .pSTAT_WIDTH(pSTAT_WIDTH),
    .pSTAGES    (pSTAGES)
  ) u_cmp (
    .pattern_i(pattern_q),
    .mask_i   (mask_q),
    .stat_i   (I_fe_capture_stat),
    .match_o  (matchVec)
  );

  // Pad per-stage vectors to a power of two so stage indices select without range checks.
  assign matchPad = {{(pIDX - pSTAGES){1'b0}}, matchVec};
  for (genvar k = 0; k < pIDX; k++) begin : g_hold
    if (k < pSTAGES) begin : g_used
      assign holdArr[k] = hold_q[k*pHOLD_WIDTH +: pHOLD_WIDTH];
    end else begin : g_pad
      assign holdArr[k] = '0;
    end
  end

  assign startEv  = I_arm & (~armPrev_q | I_update);
  assign armFall  = ~I_arm & armPrev_q;
  assign numEff   = pSTG_W'(clampStages(int'(I_num_stages), pSTAGES));
  assign lastStg  = numStg_q - pSTG_W'(1);
  assign nextStg  = stage_q + pSTG_W'(1);
  assign timerInc = (&timer_q) ? timer_q : timer_q + pTS_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    matched_d = matched_q;
    pulse_d   = 1'b0;
    mStat_d   = mStat_q;
    mTime_d   = mTime_q;
    evalEn    = 1'b0;
    candStg   = '0;
    candCnt   = '0;
    if (startEv) begin
      state_d   = HOLD;
      stage_d   = '0;
      cnt_d     = '0;
      timer_d   = '0;
      matched_d = 1'b0;
      mStat_d   = '0;
      mTime_d   = '0;
    end else if (armFall) begin
      state_d = IDLE;
    end else begin
      // Pick the stage this sample is judged against; a miss falls back to stage 0.
      case (state_q)
        HOLD: begin
          timer_d = timerInc;
          evalEn  = 1'b1;
          if (matchPad[stage_q]) begin
            candStg = stage_q;
            candCnt = cnt_q;
          end
        end
        WAIT_NEXT: begin
          timer_d = timerInc;
          if (matchPad[nextStg]) begin
            evalEn  = 1'b1;
            candStg = nextStg;
          end else if (!matchPad[stage_q]) begin
            evalEn = 1'b1;
          end
        end
        default: ;
      endcase
      if (evalEn) begin
        if (!matchPad[candStg]) begin
          state_d = HOLD;
          stage_d = '0;
          cnt_d   = '0;
        end else if (candCnt == holdArr[candStg]) begin
          stage_d = candStg;
          cnt_d   = '0;
          if (candStg == lastStg) begin
            state_d   = DONE;
            matched_d = 1'b1;
            pulse_d   = 1'b1;
            mStat_d   = I_fe_capture_stat;
            mTime_d   = timerInc;
          end else begin
            state_d = WAIT_NEXT;
          end
        end else begin
          state_d = HOLD;
          stage_d = candStg;
          cnt_d   = candCnt + pHOLD_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      matched_q <= 1'b0;
      pulse_q   <= 1'b0;
      mStat_q   <= '0;
      mTime_q   <= '0;
      armPrev_q <= 1'b0;
      pattern_q <= '0;
      mask_q    <= '0;
      hold_q    <= '0;
      numStg_q  <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      matched_q <= matched_d;
      pulse_q   <= pulse_d;
      mStat_q   <= mStat_d;
      mTime_q   <= mTime_d;
      armPrev_q <= I_arm;
      if (startEv) begin
        pattern_q <= I_pattern;
        mask_q    <= I_mask;
        hold_q    <= I_hold;
        numStg_q  <= numEff;
      end
    end
  end

  assign O_match_pulse = pulse_q;
  assign O_matched     = matched_q;
  assign O_busy        = (state_q == HOLD) || (state_q == WAIT_NEXT);
  assign O_stage       = stage_q;
  assign O_match_stat  = mStat_q;
  assign O_match_time  = mTime_q;

endmodule

// File: tb/tb_usb_stat_seq_matcher.sv
// Self-checking bench: directed scenarios plus randomized runs against a
// behavioural sequence model; a 4-bit timestamp copy checks saturation.
module tb_usb_stat_seq_matcher;

  localparam int SW   = 5;
  localparam int NS   = 4;
  localparam int HW   = 8;
  localparam int STGW = $clog2(NS + 1);

  logic              clk, rst, armIn, updIn;
  logic [STGW-1:0]   numIn;
  logic [NS*SW-1:0]  patIn, mskIn;
  logic [NS*HW-1:0]  holdIn;
  logic [SW-1:0]     statIn;

  logic              pulseA, matchedA, busyA, pulseB, matchedB, busyB;
  logic [STGW-1:0]   stageA, stageB;
  logic [SW-1:0]     statA, statB;
  logic [15:0]       timeA;
  logic [3:0]        timeB;

  usb_stat_seq_matcher #(.pSTAT_WIDTH(SW), .pSTAGES(NS), .pHOLD_WIDTH(HW), .pTS_WIDTH(16)) dutA (
    .fe_clk(clk), .reset_i(rst), .I_arm(armIn), .I_update(updIn), .I_num_stages(numIn),
    .I_pattern(patIn), .I_mask(mskIn), .I_hold(holdIn), .I_fe_capture_stat(statIn),
    .O_match_pulse(pulseA), .O_matched(matchedA), .O_busy(busyA), .O_stage(stageA),
    .O_match_stat(statA), .O_match_time(timeA)
  );

  usb_stat_seq_matcher #(.pSTAT_WIDTH(SW), .pSTAGES(NS), .pHOLD_WIDTH(HW), .pTS_WIDTH(4)) dutB (
    .fe_clk(clk), .reset_i(rst), .I_arm(armIn), .I_update(updIn), .I_num_stages(numIn),
    .I_pattern(patIn), .I_mask(mskIn), .I_hold(holdIn), .I_fe_capture_stat(statIn),
    .O_match_pulse(pulseB), .O_matched(matchedB), .O_busy(busyB), .O_stage(stageB),
    .O_match_stat(statB), .O_match_time(timeB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 searching, 2 complete; mWait means stage mStage is already satisfied.
  int mMode, mWait, mStage, mCnt, mTimer, mMatched, mPulse, mStat, mTimeRaw, mArmPrev, mNum;
  int mPat [NS];
  int mMsk [NS];
  int mHold[NS];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mHit(input int s, input int st);
    return ((st & mMsk[s]) == (mPat[s] & mMsk[s]));
  endfunction

  task automatic modelReset();
    mMode = 0; mWait = 0; mStage = 0; mCnt = 0; mTimer = 0; mMatched = 0;
    mPulse = 0; mStat = 0; mTimeRaw = 0; mArmPrev = 0; mNum = 0;
    for (int k = 0; k < NS; k++) begin
      mPat[k] = 0; mMsk[k] = 0; mHold[k] = 0;
    end
  endtask

  task automatic modelTry(input int s, input int c, input int st);
    if (!mHit(s, st)) begin
      mStage = 0; mCnt = 0; mWait = 0;
    end else if (c == mHold[s]) begin
      mStage = s; mCnt = 0;
      if (s == mNum - 1) begin
        mMode = 2; mWait = 0; mMatched = 1; mPulse = 1; mStat = st; mTimeRaw = mTimer;
      end else begin
        mWait = 1;
      end
    end else begin
      mWait = 0; mStage = s; mCnt = c + 1;
    end
  endtask

  task automatic modelStep();
    int st;
    int n;
    bit start, fall;
    st    = int'(statIn);
    start = armIn && (mArmPrev == 0 || updIn);
    fall  = !armIn && (mArmPrev != 0);
    mArmPrev = armIn ? 1 : 0;
    mPulse = 0;
    if (start) begin
      for (int k = 0; k < NS; k++) begin
        mPat[k]  = int'(patIn[k*SW +: SW]);
        mMsk[k]  = int'(mskIn[k*SW +: SW]);
        mHold[k] = int'(holdIn[k*HW +: HW]);
      end
      n = int'(numIn);
      mNum = (n == 0) ? 1 : ((n > NS) ? NS : n);
      mMode = 1; mWait = 0; mStage = 0; mCnt = 0; mTimer = 0;
      mMatched = 0; mStat = 0; mTimeRaw = 0;
    end else if (fall) begin
      mMode = 0;
    end else if (mMode == 1) begin
      mTimer++;
      if (mWait != 0 && mHit(mStage + 1, st)) modelTry(mStage + 1, 0, st);
      else if (mWait != 0 && mHit(mStage, st)) begin end
      else if (mWait == 0 && mHit(mStage, st)) modelTry(mStage, mCnt, st);
      else modelTry(0, 0, st);
    end
  endtask

  task automatic checkAll();
    int tA, tB;
    tA = (mTimeRaw > 65535) ? 65535 : mTimeRaw;
    tB = (mTimeRaw > 15) ? 15 : mTimeRaw;
    checkOutput("pulse", 32'(pulseA), mPulse);
    checkOutput("matched", 32'(matchedA), mMatched);
    checkOutput("busy", 32'(busyA), (mMode == 1) ? 1 : 0);
    checkOutput("match_stat", 32'(statA), mStat);
    checkOutput("match_time", 32'(timeA), tA);
    checkOutput("B_pulse", 32'(pulseB), mPulse);
    checkOutput("B_matched", 32'(matchedB), mMatched);
    checkOutput("B_busy", 32'(busyB), (mMode == 1) ? 1 : 0);
    checkOutput("B_match_stat", 32'(statB), mStat);
    checkOutput("B_match_time_sat", 32'(timeB), tB);
    if (!(mMode == 1 && mWait != 0)) begin
      checkOutput("stage", 32'(stageA), mStage);
      checkOutput("B_stage", 32'(stageB), mStage);
    end
  endtask

  task automatic applyStimulus(input int arm, input int upd, input int stat);
    armIn  = (arm != 0);
    updIn  = (upd != 0);
    statIn = SW'(stat);
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic setStage(input int k, input int p, input int m, input int h);
    patIn[k*SW +: SW] = SW'(p);
    mskIn[k*SW +: SW] = SW'(m);
    holdIn[k*HW +: HW] = HW'(h);
  endtask

  initial begin
    int k;
    rst = 1'b1; armIn = 1'b0; updIn = 1'b0; numIn = '0;
    patIn = '0; mskIn = '0; holdIn = '0; statIn = '0;
    modelReset();
    #12;
    checkAll();
    rst = 1'b0;

    // One stage; the start-cycle sample would match but must be ignored.
    numIn = STGW'(1); setStage(0, 5'h01, 5'h03, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 5'h01);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h05);
    checkOutput("tp1_pulse", 32'(pulseA), 1);
    checkOutput("tp1_stat", 32'(statA), 5);
    checkOutput("tp1_time", 32'(timeA), 3);
    applyStimulus(1, 0, 5'h05);
    checkOutput("tp1_pulse_once", 32'(pulseA), 0);

    // SE0 hold 2 then J.
    numIn = STGW'(2); setStage(0, 5'h00, 5'h03, 2); setStage(1, 5'h01, 5'h03, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h01);
    checkOutput("tp2_pulse", 32'(pulseA), 1);
    checkOutput("tp2_time", 32'(timeA), 4);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h01);
    checkOutput("tp2_short_matched", 32'(matchedA), 0);
    checkOutput("tp2_short_stage", 32'(stageA), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h01);
    checkOutput("tp2_retry_pulse", 32'(pulseA), 1);

    // Three stages, abort at stage 2 with stage 0's pattern; later pattern edits are ignored.
    numIn = STGW'(3);
    setStage(0, 5'h00, 5'h03, 1); setStage(1, 5'h01, 5'h03, 0); setStage(2, 5'h02, 5'h03, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h01);
    applyStimulus(1, 0, 5'h02);
    applyStimulus(1, 0, 5'h00);
    checkOutput("tp3_abort_stage", 32'(stageA), 0);
    checkOutput("tp3_abort_busy", 32'(busyA), 1);
    setStage(2, 5'h03, 5'h03, 1);
    applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h01);
    applyStimulus(1, 0, 5'h02);
    applyStimulus(1, 0, 5'h02);
    checkOutput("tp3_pulse", 32'(pulseA), 1);
    checkOutput("tp3_time", 32'(timeA), 9);
    applyStimulus(0, 0, 0);
    checkOutput("done_drop_matched", 32'(matchedA), 1);
    checkOutput("done_drop_busy", 32'(busyA), 0);

    // Stage-count clamping: 0 acts as 1, 7 acts as 4.
    numIn = STGW'(0);
    setStage(0, 5'h03, 5'h1F, 0); setStage(1, 5'h02, 5'h1F, 0);
    setStage(2, 5'h03, 5'h1F, 0); setStage(3, 5'h04, 5'h1F, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 5'h03);
    checkOutput("num0_pulse", 32'(pulseA), 1);
    numIn = STGW'(7);
    setStage(0, 5'h01, 5'h1F, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 5'h01);
    applyStimulus(1, 0, 5'h02);
    applyStimulus(1, 0, 5'h03);
    checkOutput("num7_not_three", 32'(matchedA), 0);
    applyStimulus(1, 0, 5'h04);
    checkOutput("num7_pulse", 32'(pulseA), 1);

    // Timestamp saturation on the 4-bit copy.
    numIn = STGW'(1); setStage(0, 5'h1F, 5'h1F, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 19; i++) applyStimulus(1, 0, 5'h00);
    applyStimulus(1, 0, 5'h1F);
    checkOutput("sat_time16", 32'(timeA), 20);
    checkOutput("sat_time4", 32'(timeB), 15);

    // Update coinciding with the arm edge, then update restarting from DONE.
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 5'h1F);
    checkOutput("upd_rise_time", 32'(timeA), 1);
    applyStimulus(1, 1, 5'h1F);
    checkOutput("upd_restart_matched", 32'(matchedA), 0);
    applyStimulus(1, 0, 5'h1F);
    checkOutput("upd_restart_pulse", 32'(pulseA), 1);

    // Arm dropped while waiting for the next stage.
    numIn = STGW'(2); setStage(0, 5'h01, 5'h1F, 0); setStage(1, 5'h02, 5'h1F, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 5'h01);
    applyStimulus(0, 0, 5'h02);
    checkOutput("wait_drop_busy", 32'(busyA), 0);

    // Asynchronous reset between clock edges with nonzero captures.
    numIn = STGW'(1); setStage(0, 5'h1F, 5'h1F, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 5'h1F);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("areset_matched", 32'(matchedA), 0);
    checkOutput("areset_time", 32'(timeA), 0);
    checkAll();
    #2 rst = 1'b0;

    // Randomized runs.
    for (int ep = 0; ep < 40; ep++) begin
      numIn = STGW'($urandom_range(0, 7));
      for (int s = 0; s < NS; s++)
        setStage(s, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, $urandom_range(0, 31));
      for (int c = 0; c < 30; c++) begin
        k = $urandom_range(0, NS - 1);
        applyStimulus(($urandom_range(0, 49) == 0) ? 0 : 1,
                      ($urandom_range(0, 39) == 0) ? 1 : 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                  : int'(patIn[k*SW +: SW]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
